// File: rtl/full_st1_tap_seq_if.sv
// Control/load/tap bundle between the stage-1 tap sequencer and its neighbours.
// The sequencer takes the slave side; the requester/testbench takes the master side.
interface full_st1_tap_seq_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic          start_i;
    logic [1:0]    mode_i;
    logic          busy_o;
    logic          done_o;
    logic          load_vld_i;
    logic          load_rdy_o;
    logic [DW-1:0] load_data_i;
    logic          tap_rd_vld_o;
    logic [AW-1:0] tap_rd_address_o;
    logic          tap_wr_vld_o;
    logic [AW-1:0] tap_wr_address_o;
    logic          tap_sub_vld_o;
    logic [2:0]    tap_sub_addr_o;
    logic [DW-1:0] tap_sub_data_o;
    logic          tap_inter_o;
    logic          tap_inter_first_o;
    logic          out_vld_o;
    logic          out_last_o;

    modport slave (
        input  start_i, mode_i, load_vld_i, load_data_i,
        output busy_o, done_o, load_rdy_o,
        output tap_rd_vld_o, tap_rd_address_o, tap_wr_vld_o, tap_wr_address_o,
        output tap_sub_vld_o, tap_sub_addr_o, tap_sub_data_o,
        output tap_inter_o, tap_inter_first_o, out_vld_o, out_last_o
    );

    modport master (
        output start_i, mode_i, load_vld_i, load_data_i,
        input  busy_o, done_o, load_rdy_o,
        input  tap_rd_vld_o, tap_rd_address_o, tap_wr_vld_o, tap_wr_address_o,
        input  tap_sub_vld_o, tap_sub_addr_o, tap_sub_data_o,
        input  tap_inter_o, tap_inter_first_o, out_vld_o, out_last_o
    );
endinterface

// File: rtl/full_st1_tap_seq.sv
// Sequencer for the stage-1 tap memory: forward sweep, interleaved sweep and
// serial word load, plus a read-data valid/last strobe for the downstream MAC.
module full_st1_tap_seq #(
    parameter int LANES     = 6,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int DW        = 32,
    parameter int INTER_LEN = 12,
    parameter int RD_LAT    = 1
) (
    input  logic clk,
    input  logic rst_n,
    full_st1_tap_seq_if.slave bus
);

    localparam int CW  = $clog2(INTER_LEN + 1);
    localparam int DRW = 4;

    typedef enum logic [2:0] {IDLE, FWD, INTER, LOAD, DRAIN} state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  row_q, row_d;
    logic [2:0]     lane_q, lane_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DRW-1:0] drain_q, drain_d;

    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           load_rdy_q, load_rdy_d;
    logic           rd_vld_q, rd_vld_d;
    logic [AW-1:0]  rd_addr_q, rd_addr_d;
    logic           wr_vld_q, wr_vld_d;
    logic [AW-1:0]  wr_addr_q, wr_addr_d;
    logic           sub_vld_q, sub_vld_d;
    logic [2:0]     sub_addr_q, sub_addr_d;
    logic [DW-1:0]  sub_data_q, sub_data_d;
    logic           inter_q, inter_d;
    logic           inter_first_q, inter_first_d;
    logic           last_q, last_d;
    logic [RD_LAT-1:0] vld_pipe_q, last_pipe_q;

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        lane_d        = lane_q;
        cnt_d         = cnt_q;
        drain_d       = drain_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        load_rdy_d    = 1'b0;
        rd_vld_d      = 1'b0;
        rd_addr_d     = '0;
        wr_vld_d      = 1'b0;
        wr_addr_d     = '0;
        sub_vld_d     = 1'b0;
        sub_addr_d    = '0;
        sub_data_d    = '0;
        inter_d       = 1'b0;
        inter_first_d = 1'b0;
        last_d        = 1'b0;

        case (state_q)
            IDLE: begin
                row_d   = '0;
                lane_d  = '0;
                cnt_d   = '0;
                drain_d = '0;
                busy_d  = 1'b0;
                if (bus.start_i) begin
                    busy_d = 1'b1;
                    case (bus.mode_i)
                        2'd0:    state_d = FWD;
                        2'd1:    state_d = INTER;
                        2'd2: begin
                            state_d    = LOAD;
                            load_rdy_d = 1'b1;
                        end
                        default: state_d = DRAIN;
                    endcase
                end
            end
            FWD: begin
                rd_vld_d  = 1'b1;
                rd_addr_d = row_q;
                row_d     = row_q + 1'b1;
                if (row_q == AW'(DEPTH - 1)) begin
                    last_d  = 1'b1;
                    state_d = DRAIN;
                    drain_d = DRW'(RD_LAT - 1);
                end
            end
            // Address stays 0 after the first cycle; the memory rotates rows itself.
            INTER: begin
                rd_vld_d      = 1'b1;
                inter_d       = 1'b1;
                inter_first_d = (cnt_q == '0);
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == CW'(INTER_LEN - 1)) begin
                    last_d  = 1'b1;
                    state_d = DRAIN;
                    drain_d = DRW'(RD_LAT - 1);
                end
            end
            LOAD: begin
                load_rdy_d = 1'b1;
                if (bus.load_vld_i && load_rdy_q) begin
                    wr_vld_d   = 1'b1;
                    sub_vld_d  = 1'b1;
                    wr_addr_d  = row_q;
                    sub_addr_d = lane_q;
                    sub_data_d = bus.load_data_i;
                    if (lane_q == 3'(LANES - 1)) begin
                        lane_d = '0;
                        row_d  = row_q + 1'b1;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                    if (lane_q == 3'(LANES - 1) && row_q == AW'(DEPTH - 1)) begin
                        load_rdy_d = 1'b0;
                        state_d    = DRAIN;
                        drain_d    = '0;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            row_q         <= '0;
            lane_q        <= '0;
            cnt_q         <= '0;
            drain_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            load_rdy_q    <= 1'b0;
            rd_vld_q      <= 1'b0;
            rd_addr_q     <= '0;
            wr_vld_q      <= 1'b0;
            wr_addr_q     <= '0;
            sub_vld_q     <= 1'b0;
            sub_addr_q    <= '0;
            sub_data_q    <= '0;
            inter_q       <= 1'b0;
            inter_first_q <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            lane_q        <= lane_d;
            cnt_q         <= cnt_d;
            drain_q       <= drain_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            load_rdy_q    <= load_rdy_d;
            rd_vld_q      <= rd_vld_d;
            rd_addr_q     <= rd_addr_d;
            wr_vld_q      <= wr_vld_d;
            wr_addr_q     <= wr_addr_d;
            sub_vld_q     <= sub_vld_d;
            sub_addr_q    <= sub_addr_d;
            sub_data_q    <= sub_data_d;
            inter_q       <= inter_d;
            inter_first_q <= inter_first_d;
            last_q        <= last_d;
        end
    end

    // Delay line matching the memory read latency so out_vld lines up with read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            vld_pipe_q[0]  <= rd_vld_q;
            last_pipe_q[0] <= last_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_q[i]  <= vld_pipe_q[i-1];
                last_pipe_q[i] <= last_pipe_q[i-1];
            end
        end
    end

    assign bus.busy_o            = busy_q;
    assign bus.done_o            = done_q;
    assign bus.load_rdy_o        = load_rdy_q;
    assign bus.tap_rd_vld_o      = rd_vld_q;
    assign bus.tap_rd_address_o  = rd_addr_q;
    assign bus.tap_wr_vld_o      = wr_vld_q;
    assign bus.tap_wr_address_o  = wr_addr_q;
    assign bus.tap_sub_vld_o     = sub_vld_q;
    assign bus.tap_sub_addr_o    = sub_addr_q;
    assign bus.tap_sub_data_o    = sub_data_q;
    assign bus.tap_inter_o       = inter_q;
    assign bus.tap_inter_first_o = inter_first_q;
    assign bus.out_vld_o         = vld_pipe_q[RD_LAT-1];
    assign bus.out_last_o        = last_pipe_q[RD_LAT-1];

endmodule

// File: tb/tb_full_st1_tap_seq.sv
// Directed bench for full_st1_tap_seq with a small tap-memory model used to
// read back loaded words through a forward sweep.
module tb_full_st1_tap_seq;

    logic clk;
    logic rst_n;

    full_st1_tap_seq_if #(.AW(4), .DW(32)) bus ();

    full_st1_tap_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;

    logic [31:0]  mem [16][6];
    logic [191:0] rdRow;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural tap memory: sub-word writes, one-cycle registered row read.
    always @(posedge clk) begin
        if (bus.tap_wr_vld_o && bus.tap_sub_vld_o)
            mem[bus.tap_wr_address_o][bus.tap_sub_addr_o] <= bus.tap_sub_data_o;
        if (bus.tap_rd_vld_o)
            for (int j = 0; j < 6; j++)
                rdRow[j*32 +: 32] <= mem[bus.tap_rd_address_o][j];
    end

    function automatic logic [191:0] allOuts();
        return 192'({bus.busy_o, bus.done_o, bus.load_rdy_o, bus.tap_rd_vld_o,
                     bus.tap_rd_address_o, bus.tap_wr_vld_o, bus.tap_wr_address_o,
                     bus.tap_sub_vld_o, bus.tap_sub_addr_o, bus.tap_sub_data_o,
                     bus.tap_inter_o, bus.tap_inter_first_o, bus.out_vld_o, bus.out_last_o});
    endfunction

    function automatic logic [191:0] tapOuts();
        return 192'({bus.load_rdy_o, bus.tap_rd_vld_o, bus.tap_rd_address_o,
                     bus.tap_wr_vld_o, bus.tap_wr_address_o, bus.tap_sub_vld_o,
                     bus.tap_sub_addr_o, bus.tap_sub_data_o, bus.tap_inter_o,
                     bus.tap_inter_first_o, bus.out_vld_o, bus.out_last_o});
    endfunction

    function automatic logic [191:0] expRow(int r);
        logic [191:0] v;
        for (int j = 0; j < 6; j++)
            v[j*32 +: 32] = 32'(32'h1000 + r * 6 + j);
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the current inputs; outputs are then sampled at the falling edge.
    task automatic applyStimulus();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fwdSweep(input bit readback, input bit holdStart);
        bus.start_i = 1'b1;
        bus.mode_i  = 2'd0;
        applyStimulus();
        checkOutput("fwd_busy_c0", 192'(bus.busy_o), 192'(1));
        checkOutput("fwd_rdvld_c0", 192'(bus.tap_rd_vld_o), 192'(0));
        if (!holdStart) bus.start_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (holdStart && i == 4) bus.mode_i = 2'd1;
            applyStimulus();
            checkOutput($sformatf("fwd_rdvld_%0d", i), 192'(bus.tap_rd_vld_o), 192'(1));
            checkOutput($sformatf("fwd_addr_%0d", i), 192'(bus.tap_rd_address_o), 192'(i));
            checkOutput($sformatf("fwd_outvld_%0d", i), 192'(bus.out_vld_o), 192'(i > 0));
            checkOutput($sformatf("fwd_done_%0d", i), 192'({bus.done_o, bus.out_last_o}), 192'(0));
            checkOutput($sformatf("fwd_busy_%0d", i), 192'(bus.busy_o), 192'(1));
            if (readback && i > 0)
                checkOutput($sformatf("readback_row_%0d", i - 1), rdRow, expRow(i - 1));
        end
        applyStimulus();
        checkOutput("fwd_end", 192'({bus.done_o, bus.out_last_o, bus.out_vld_o, bus.busy_o, bus.tap_rd_vld_o}),
                    192'(5'b11100));
        if (readback) checkOutput("readback_row_15", rdRow, expRow(15));
        bus.start_i = 1'b0;
        bus.mode_i  = 2'd0;
        applyStimulus();
        checkOutput("fwd_idle_after", allOuts(), 192'(0));
    endtask

    initial begin
        int k;
        int writes;
        logic anyOut;
        bit vld;

        rst_n           = 1'b0;
        bus.start_i     = 1'b0;
        bus.mode_i      = 2'd0;
        bus.load_vld_i  = 1'b0;
        bus.load_data_i = '0;

        // Reset held with the clock running, then quiet idle after release.
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", allOuts(), 192'(0));
        rst_n  = 1'b1;
        anyOut = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            anyOut = anyOut | (|allOuts());
        end
        checkOutput("idle_20_cycles", 192'(anyOut), 192'(0));

        $display("[TB] forward sweep");
        fwdSweep(1'b0, 1'b0);

        $display("[TB] interleaved sweep");
        bus.start_i = 1'b1;
        bus.mode_i  = 2'd1;
        applyStimulus();
        checkOutput("int_c0", 192'({bus.busy_o, bus.tap_inter_o, bus.tap_rd_vld_o}), 192'(3'b100));
        bus.start_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
            checkOutput($sformatf("int_inter_%0d", i), 192'({bus.tap_inter_o, bus.tap_rd_vld_o}), 192'(2'b11));
            checkOutput($sformatf("int_first_%0d", i), 192'(bus.tap_inter_first_o), 192'(i == 0));
            checkOutput($sformatf("int_addr_%0d", i), 192'(bus.tap_rd_address_o), 192'(0));
            checkOutput($sformatf("int_done_%0d", i), 192'(bus.done_o), 192'(0));
        end
        applyStimulus();
        checkOutput("int_end", 192'({bus.done_o, bus.out_last_o, bus.out_vld_o, bus.busy_o, bus.tap_inter_o}),
                    192'(5'b11100));
        applyStimulus();
        checkOutput("int_idle_after", allOuts(), 192'(0));

        $display("[TB] serial load of 96 words");
        bus.start_i = 1'b1;
        bus.mode_i  = 2'd2;
        applyStimulus();
        checkOutput("load_c0", 192'({bus.busy_o, bus.load_rdy_o, bus.tap_wr_vld_o}), 192'(3'b110));
        bus.start_i = 1'b0;
        k      = 0;
        writes = 0;
        for (int cyc = 0; cyc < 400 && k < 96; cyc++) begin
            vld             = (cyc % 2 == 0);
            bus.load_vld_i  = vld;
            bus.load_data_i = 32'(32'h1000 + k);
            applyStimulus();
            if (bus.tap_wr_vld_o) writes++;
            checkOutput($sformatf("load_wrvld_%0d", cyc), 192'({bus.tap_wr_vld_o, bus.tap_sub_vld_o}),
                        192'({vld, vld}));
            checkOutput($sformatf("load_rdvld_%0d", cyc), 192'(bus.tap_rd_vld_o), 192'(0));
            checkOutput($sformatf("load_rdy_%0d", cyc), 192'(bus.load_rdy_o), 192'(!(vld && k == 95)));
            if (vld) begin
                checkOutput($sformatf("load_word_%0d", k),
                            192'({bus.tap_wr_address_o, bus.tap_sub_addr_o, bus.tap_sub_data_o}),
                            192'({4'(k / 6), 3'(k % 6), 32'(32'h1000 + k)}));
                if (k == 7)
                    checkOutput("load_word7_pos", 192'({bus.tap_wr_address_o, bus.tap_sub_addr_o}),
                                192'({4'd1, 3'd1}));
                if (k == 95)
                    checkOutput("load_word95_pos", 192'({bus.tap_wr_address_o, bus.tap_sub_addr_o}),
                                192'({4'd15, 3'd5}));
                k++;
            end
        end
        checkOutput("load_words_sent", 192'(k), 192'(96));
        bus.load_vld_i = 1'b0;
        applyStimulus();
        checkOutput("load_end", 192'({bus.done_o, bus.busy_o, bus.tap_wr_vld_o, bus.load_rdy_o}), 192'(4'b1000));
        checkOutput("load_write_count", 192'(writes), 192'(96));
        applyStimulus();
        checkOutput("load_idle_after", allOuts(), 192'(0));

        $display("[TB] readback sweep");
        fwdSweep(1'b1, 1'b0);

        $display("[TB] held start and null mode");
        fwdSweep(1'b0, 1'b1);
        bus.start_i = 1'b1;
        bus.mode_i  = 2'd3;
        applyStimulus();
        checkOutput("null_c0", 192'({bus.busy_o, bus.done_o}), 192'(2'b10));
        checkOutput("null_taps_c0", tapOuts(), 192'(0));
        bus.start_i = 1'b0;
        bus.mode_i  = 2'd0;
        applyStimulus();
        checkOutput("null_done", 192'({bus.busy_o, bus.done_o}), 192'(2'b01));
        checkOutput("null_taps_done", tapOuts(), 192'(0));
        applyStimulus();
        checkOutput("null_idle_after", allOuts(), 192'(0));

        $display("[TB] reset mid forward sweep");
        bus.start_i = 1'b1;
        applyStimulus();
        bus.start_i = 1'b0;
        repeat (6) applyStimulus();
        checkOutput("abort_addr5", 192'({bus.tap_rd_vld_o, bus.tap_rd_address_o}), 192'({1'b1, 4'd5}));
        rst_n = 1'b0;
        #1;
        checkOutput("abort_async_zero", allOuts(), 192'(0));
        @(negedge clk);
        rst_n  = 1'b1;
        anyOut = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            anyOut = anyOut | (|allOuts());
        end
        checkOutput("abort_no_done", 192'(anyOut), 192'(0));
        fwdSweep(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/full_st1_tap_seq.md
Name: full_st1_tap_seq

Overview:
- Control sequencer directly upstream of the stage-1 tap memory (6 lanes x 32 b, 4-bit address). Drives every field of that memory's tap control interface.
- Three operations:
  - Forward sweep: row-by-row reads of all taps.
  - Interleaved (transpose) sweep: uses the memory's inter/inter_first rotation.
  - Serial load: writes one 32-bit word at a time through the sub-word write path.
- Also produces a valid/last strobe aligned to the memory's read data for the downstream MAC.

Parameters:
- LANES, 6, number of 32-bit lanes (sub_addr range 0..LANES-1).
- DEPTH, 16, rows per lane; the forward sweep and load cover rows 0..DEPTH-1.
- AW, 4, address width.
- DW, 32, lane/word width.
- INTER_LEN, 12, total cycles of an interleaved sweep, including the first (inter_first) cycle.
- RD_LAT, 1, tap memory read latency in cycles.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle operation request; sampled only in IDLE.
- mode  in  2  0=forward, 1=interleave, 2=load, 3=null.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at operation end.
- load_vld  in  1  load word valid.
- load_rdy  out  1  load word ready.
- load_data  in  DW  load word.
- tap_rd_vld  out  1  memory read enable.
- tap_rd_address  out  AW  memory read row.
- tap_wr_vld  out  1  memory write enable.
- tap_wr_address  out  AW  memory write row.
- tap_sub_vld  out  1  sub-word write select.
- tap_sub_addr  out  3  lane for the sub-word write.
- tap_sub_data  out  DW  sub-word write data.
- tap_inter  out  1  interleave-read enable.
- tap_inter_first  out  1  interleave counter restart.
- out_vld  out  1  memory read data valid (tap_rd_vld delayed RD_LAT).
- out_last  out  1  qualifies the final out_vld of a sweep.

Behaviour:
- Reset (async assert, sync deassert):
  - State IDLE; row and lane counters 0.
  - All outputs 0, including the read-latency pipe.
  - Asserting reset mid-operation aborts immediately; no done pulse.
- All tap_* outputs, load_rdy, busy, done, out_vld and out_last are registered.
- States: IDLE, FWD, INTER, LOAD, DRAIN.
- IDLE, on start:
  - mode 0 -> FWD; mode 1 -> INTER; mode 2 -> LOAD.
  - mode 3 -> DRAIN with no memory activity.
  - start while busy is ignored.
- FWD:
  - tap_rd_vld=1 for DEPTH consecutive cycles; tap_rd_address = 0,1,...,DEPTH-1.
  - After the last read -> DRAIN.
- INTER:
  - tap_rd_vld=1 and tap_inter=1 for INTER_LEN cycles.
  - Cycle 0 only: tap_inter_first=1 and tap_rd_address=0.
  - Remaining cycles: tap_inter_first=0 and tap_rd_address held 0; the memory rotates addresses internally.
  - After the last cycle -> DRAIN.
- LOAD:
  - load_rdy=1 for the whole state, except 0 in the cycle after the final word is accepted.
  - Word k (k = 0..DEPTH*LANES-1) accepted on load_vld & load_rdy. Next cycle: tap_wr_vld=1, tap_sub_vld=1, tap_sub_addr = k mod LANES, tap_wr_address = k / LANES, tap_sub_data = word.
  - Lane counter wraps 5->0 and increments the row counter.
  - load_vld low -> no write that cycle; counters hold.
  - After the write of word DEPTH*LANES-1 -> DRAIN.
- DRAIN:
  - Lasts RD_LAT cycles for FWD/INTER, 1 cycle otherwise.
  - done=1 in the final DRAIN cycle; busy falls in the same cycle.
  - Return to IDLE.
- Output pipe:
  - out_vld = tap_rd_vld delayed RD_LAT.
  - out_last = (last read of FWD/INTER) delayed RD_LAT.
  - done coincides with out_last for FWD/INTER.
- Idle values: tap_wr_vld, tap_sub_vld, tap_inter and tap_inter_first are never asserted outside LOAD/INTER; tap_rd_vld is 0 in LOAD.
- Widths: row counter AW bits; lane counter 3 bits; no overflow is possible with the defaults.

Test Plan:
- Reset held low, clock running: every output 0; release reset, no start -> outputs stay 0 for 20 cycles.
- start with mode=0: rd_address steps 0..15 with rd_vld on 16 cycles; out_vld is the same pattern one cycle later; out_last and done both fire on the 17th cycle after the first read.
- start with mode=1: 12 cycles of tap_inter; tap_inter_first only on the first cycle; rd_address stays 0 throughout; done follows 1 cycle after the last inter cycle.
- start with mode=2, 96 words 0x1000+k, load_vld toggling 1/0: 96 writes total; word 7 lands at wr_address 1, sub_addr 1; word 95 lands at wr_address 15, sub_addr 5; a readback forward sweep returns the packed rows.
- start held high during FWD, plus start with mode=3: the held start is ignored until done; mode=3 -> busy for 1 cycle, done, no tap_* activity.
- reset asserted at FWD row 5: outputs 0 asynchronously; a new mode=0 start after release sweeps from row 0.
